// File: rtl/sisc_pkg.sv
// Shared SISC definitions: responder states, default widths, LOD/STR opcodes.
// Used by the control FSM and the data-memory responder.
package sisc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W      = 4;

  localparam logic OP_LOD = 1'b0;
  localparam logic OP_STR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/sisc_dmem_array.sv
// Single-port word array: synchronous write, combinational read.
// With SISC_DMEM_PARITY_EN a parity bit is stored beside each word.
module sisc_dmem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
`ifdef SISC_DMEM_PARITY_EN
  input  logic                  wpar,
  output logic                  rpar,
`endif
  output logic [DATA_W-1:0]     rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

`ifdef SISC_DMEM_PARITY_EN
  logic par_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      par_q[addr] <= wpar;
    end
  end

  assign rpar = par_q[addr];
`endif

endmodule

// File: rtl/sisc_dmem_resp.sv
// SISC data-memory responder: request/response handshakes, wait states.
// Optional word parity via SISC_DMEM_PARITY_EN.
module sisc_dmem_resp
  import sisc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef SISC_DMEM_PARITY_EN
  input  logic              inj_par_err,
`endif
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rsp_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_rdy_q, req_rdy_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;

  logic              commit;
  logic              in_idle;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;
  logic              par_err;

  // Zero wait states commit straight from IDLE, before the latch is loaded.
  assign in_idle   = (state_q == ST_IDLE);
  assign acc_we    = in_idle ? req_we    : we_q;
  assign acc_addr  = in_idle ? req_addr  : addr_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;

  assign in_range = (acc_addr[ADDR_W-1:DEPTH_LOG2] == '0);
  assign arr_we   = commit && (acc_we == OP_STR) && in_range;

`ifdef SISC_DMEM_PARITY_EN
  logic inj_q, inj_d;
  logic acc_inj;
  logic arr_wpar;
  logic arr_rpar;

  assign acc_inj  = in_idle ? inj_par_err : inj_q;
  assign arr_wpar = (^acc_wdata) ^ acc_inj;
  assign par_err  = (^arr_rdata) != arr_rpar;
`else
  assign par_err  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;
`ifdef SISC_DMEM_PARITY_EN
    inj_d       = inj_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_vld && req_rdy_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_INIT;
`ifdef SISC_DMEM_PARITY_EN
          inj_d   = inj_par_err;
`endif
          if (WAIT_CYC == 0) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      rsp_err_d   = !in_range ||
                    ((acc_we == OP_LOD) && par_err);
      rsp_rdata_d = ((acc_we == OP_LOD) && in_range) ?
                    arr_rdata : '0;
    end

    req_rdy_d = (state_d == ST_IDLE);
    rsp_vld_d = (state_d == ST_RESP);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_rdy_q   <= 1'b1;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SISC_DMEM_PARITY_EN
      inj_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_rdy_q   <= req_rdy_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
`ifdef SISC_DMEM_PARITY_EN
      inj_q       <= inj_d;
`endif
    end
  end

  sisc_dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (acc_addr[DEPTH_LOG2-1:0]),
    .wdata (acc_wdata),
`ifdef SISC_DMEM_PARITY_EN
    .wpar  (arr_wpar),
    .rpar  (arr_rpar),
`endif
    .rdata (arr_rdata)
  );

  assign req_rdy   = req_rdy_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sisc_dmem_resp.sv
// Scoreboard bench for sisc_dmem_resp (WAIT_CYC=2 main, WAIT_CYC=0 aux).
// Parity checks are built when SISC_DMEM_PARITY_EN is defined.
module tb_sisc_dmem_resp;

  localparam int W = 2;
`ifdef SISC_DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_vld = 1'b0;
  logic        a_req_rdy;
  logic        a_req_we = 1'b0;
  logic [15:0] a_req_addr = '0;
  logic [31:0] a_req_wdata = '0;
  logic        a_inj = 1'b0;
  logic        a_rsp_vld;
  logic        a_rsp_rdy = 1'b1;
  logic [31:0] a_rsp_rdata;
  logic        a_rsp_err;
  logic        a_busy;

  logic        b_req_vld = 1'b0;
  logic        b_req_rdy;
  logic        b_req_we = 1'b0;
  logic [15:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_rsp_vld;
  logic        b_rsp_rdy = 1'b1;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_err;
  logic        b_busy;

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int stall = 0;
  bit bp = 1'b0;

  exp_t q[$];
  exp_t bq[$];
  logic [31:0] mem_m [256];
  bit          pbad [256];

  sisc_dmem_resp #(
    .DATA_W(32), .ADDR_W(16), .DEPTH_LOG2(8), .WAIT_CYC(W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_vld(a_req_vld), .req_rdy(a_req_rdy),
    .req_we(a_req_we), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata),
`ifdef SISC_DMEM_PARITY_EN
    .inj_par_err(a_inj),
`endif
    .rsp_vld(a_rsp_vld), .rsp_rdy(a_rsp_rdy),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .busy(a_busy)
  );

  sisc_dmem_resp #(
    .DATA_W(32), .ADDR_W(16), .DEPTH_LOG2(8), .WAIT_CYC(0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .req_vld(b_req_vld), .req_rdy(b_req_rdy),
    .req_we(b_req_we), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata),
`ifdef SISC_DMEM_PARITY_EN
    .inj_par_err(1'b0),
`endif
    .rsp_vld(b_rsp_vld), .rsp_rdy(b_rsp_rdy),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .busy(b_busy)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Reference memory: words addressed below 256, everything else errors.
  function automatic exp_t model(input logic we, input logic [15:0] addr,
                                 input logic [31:0] data, input logic inj);
    exp_t e;
    e.we = we;
    e.addr = addr;
    e.acc = 0;
    if (addr >= 16'd256) begin
      e.data = 32'd0;
      e.err = 1'b1;
    end else if (we) begin
      mem_m[addr[7:0]] = data;
      pbad[addr[7:0]] = inj;
      e.data = 32'd0;
      e.err = 1'b0;
    end else begin
      e.data = mem_m[addr[7:0]];
      e.err = pbad[addr[7:0]];
    end
    return e;
  endfunction

  task automatic do_req(input logic we, input logic [15:0] addr,
                        input logic [31:0] data, input logic inj);
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    a_req_vld = 1'b1;
    a_req_we = we;
    a_req_addr = addr;
    a_req_wdata = data;
    a_inj = inj;
    n = 0;
    forever begin
      @(negedge clk);
      if (a_req_rdy) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) begin
      cmp++;
      bad++;
      $display("FAIL accept_timeout: got req_rdy=0 for 50 cycles want 1");
    end else begin
      e = model(we, addr, data, PAR ? inj : 1'b0);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    a_req_vld = 1'b0;
    a_req_we = 1'($urandom);
    a_req_addr = 16'($urandom);
    a_req_wdata = $urandom;
    a_inj = 1'($urandom);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall > 0) begin
      a_rsp_rdy = 1'b0;
      stall--;
    end else begin
      a_rsp_rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Main monitor: new response compared, stalled response must hold.
  initial begin
    exp_t cur;
    logic [31:0] hd;
    logic he;
    bit cont;
    cont = 1'b0;
    hd = '0;
    he = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cont = 1'b0;
      end else begin
        if (a_rsp_vld) begin
          if (!cont) begin
            if (q.size() == 0) begin
              cmp++;
              bad++;
              $display("FAIL spurious_rsp: got rsp_vld=1 want 0");
            end else begin
              cur = q.pop_front();
              chk("latency", 32'(cyc - cur.acc), 32'(W + 1));
              chk("rdata", a_rsp_rdata, cur.data);
              chk("err", 32'(a_rsp_err), 32'(cur.err));
            end
            hd = a_rsp_rdata;
            he = a_rsp_err;
          end else begin
            chk("hold_rdata", a_rsp_rdata, hd);
            chk("hold_err", 32'(a_rsp_err), 32'(he));
          end
          chk("req_rdy_in_resp", 32'(a_req_rdy), 32'd0);
        end
        cont = a_rsp_vld && !a_rsp_rdy;
      end
    end
  end

  // Zero-wait monitor: response must follow its accept by one cycle.
  initial begin
    exp_t cur;
    bit acc_prev;
    acc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_prev = 1'b0;
      end else begin
        if (b_rsp_vld) begin
          chk("b_latency", 32'(acc_prev), 32'd1);
          if (bq.size() == 0) begin
            cmp++;
            bad++;
            $display("FAIL b_spurious_rsp: got rsp_vld=1 want 0");
          end else begin
            cur = bq.pop_front();
            chk("b_rdata", b_rsp_rdata, cur.data);
            chk("b_err", 32'(b_rsp_err), 32'(cur.err));
          end
        end
        acc_prev = b_req_vld && b_req_rdy;
      end
    end
  end

  task automatic check_idle(input string n);
    chk({n, "_req_rdy"}, 32'(a_req_rdy), 32'd1);
    chk({n, "_rsp_vld"}, 32'(a_rsp_vld), 32'd0);
    chk({n, "_busy"}, 32'(a_busy), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bq.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_q", 32'(q.size()), 32'd0);
    chk("drain_bq", 32'(bq.size()), 32'd0);
  endtask

  initial begin
    exp_t bl[$];
    exp_t e;
    int idx;
    int n;
    int last_acc;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_rdata", a_rsp_rdata, 32'd0);
    chk("reset_err", 32'(a_rsp_err), 32'd0);
    chk("reset_b_rdy", 32'(b_req_rdy), 32'd1);
    chk("reset_b_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) do_req(1'b1, 16'(i), 32'd0, 1'b0);

    do_req(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
    stall = 7;
    do_req(1'b0, 16'h0010, 32'd0, 1'b0);
    do_req(1'b1, 16'h0100, 32'h12345678, 1'b0);
    do_req(1'b0, 16'h0000, 32'd0, 1'b0);
    drain();

    // Store cut off by reset before its commit edge.
    @(posedge clk);
    #1;
    a_req_vld = 1'b1;
    a_req_we = 1'b1;
    a_req_addr = 16'h0020;
    a_req_wdata = 32'hA5A5A5A5;
    n = 0;
    forever begin
      @(negedge clk);
      if (a_req_rdy || n > 50) break;
      n++;
    end
    chk("rst_test_accept", 32'(a_req_rdy), 32'd1);
    @(posedge clk);
    #1;
    a_req_vld = 1'b0;
    chk("rst_test_busy_pre", 32'(a_busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_req(1'b0, 16'h0020, 32'd0, 1'b0);
    drain();

    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      e.we = 1'b1; e.addr = 16'(16 + i); e.data = d;
      e.err = 1'b0; e.acc = 0;
      bl.push_back(e);
      e.we = 1'b0;
      bl.push_back(e);
    end
    e.we = 1'b0; e.addr = 16'h8000; e.data = '0;
    bl.push_back(e);

    idx = 0;
    last_acc = -10;
    n = 0;
    @(posedge clk);
    #1;
    b_req_vld = 1'b1;
    b_req_we = bl[0].we;
    b_req_addr = bl[0].addr;
    b_req_wdata = bl[0].data;
    while (idx < bl.size() && n < 200) begin
      @(negedge clk);
      n++;
      if (b_req_rdy) begin
        if (idx > 0) chk("b_accept_gap", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
        e = bl[idx];
        if (e.addr >= 16'd256) begin
          e.data = '0;
          e.err = 1'b1;
        end else if (e.we) begin
          e.data = '0;
        end
        bq.push_back(e);
        idx++;
        @(posedge clk);
        #1;
        if (idx < bl.size()) begin
          b_req_we = bl[idx].we;
          b_req_addr = bl[idx].addr;
          b_req_wdata = bl[idx].data;
        end else begin
          b_req_vld = 1'b0;
        end
      end
    end
    chk("b_all_accepted", 32'(idx), 32'(bl.size()));
    b_req_vld = 1'b0;
    drain();

`ifdef SISC_DMEM_PARITY_EN
    do_req(1'b1, 16'h0005, 32'h00000001, 1'b1);
    do_req(1'b0, 16'h0005, 32'd0, 1'b0);
    drain();
`endif

    bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ad;
      ad = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                      : 16'($urandom_range(0, 255));
      do_req(1'($urandom), ad, $urandom,
             PAR ? ($urandom_range(0, 7) == 0) : 1'b0);
    end
    drain();
    bp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
